// File: rtl/spi_segment_master_if.sv
// Handshake and three-wire SPI link of spi_segment_master.
// master: the initiator's view; slave: the host / responder side.
interface spi_segment_master_if;
    logic       start;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       mosi;
    logic       cs_n;

    modport master (
        input  start,
        input  data,
        output busy,
        output done,
        output sclk,
        output mosi,
        output cs_n
    );

    modport slave (
        output start,
        output data,
        input  busy,
        input  done,
        input  sclk,
        input  mosi,
        input  cs_n
    );
endinterface

// File: rtl/spi_segment_master.sv
// SPI mode-0 initiator sending one 8-bit segment pattern per frame, MSB first,
// with an optional idle timer that resends the last pattern.
module spi_segment_master #(
    parameter logic [7:0]  CLK_DIV       = 8'd4,
    parameter logic [23:0] REFRESH_COUNT = 24'd10_000_000
) (
    input logic                  clk,
    input logic                  rst,
    spi_segment_master_if.master bus
);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StGap} state_e;

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic        high_q, high_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  hold_q, hold_d;
    logic [23:0] refresh_q, refresh_d;
    logic        sent_q, sent_d;

    logic div_done;
    logic refresh_hit;

    assign div_done    = (div_q == CLK_DIV - 8'd1);
    assign refresh_hit = (REFRESH_COUNT != 24'd0) && sent_q && (refresh_q == REFRESH_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            div_q     <= 8'd0;
            bit_q     <= 3'd0;
            high_q    <= 1'b0;
            shreg_q   <= 8'd0;
            hold_q    <= 8'd0;
            refresh_q <= 24'd0;
            sent_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            high_q    <= high_d;
            shreg_q   <= shreg_d;
            hold_q    <= hold_d;
            refresh_q <= refresh_d;
            sent_q    <= sent_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        high_d    = high_q;
        shreg_d   = shreg_q;
        hold_d    = hold_q;
        refresh_d = refresh_q;
        sent_d    = sent_q;

        unique case (state_q)
            StIdle: begin
                // An explicit start beats a refresh trigger in the same cycle.
                if (bus.start) begin
                    hold_d    = bus.data;
                    shreg_d   = bus.data;
                    sent_d    = 1'b1;
                    refresh_d = 24'd0;
                    div_d     = 8'd0;
                    state_d   = StSetup;
                end else if (refresh_hit) begin
                    shreg_d   = hold_q;
                    refresh_d = 24'd0;
                    div_d     = 8'd0;
                    state_d   = StSetup;
                end else if (refresh_q != 24'hFF_FFFF) begin
                    refresh_d = refresh_q + 24'd1;
                end
            end

            StSetup: begin
                div_d = div_q + 8'd1;
                if (div_done) begin
                    div_d   = 8'd0;
                    high_d  = 1'b1;
                    bit_d   = 3'd7;
                    state_d = StShift;
                end
            end

            StShift: begin
                div_d = div_q + 8'd1;
                if (div_done) begin
                    div_d = 8'd0;
                    if (high_q) begin
                        high_d = 1'b0;
                        // Next bit appears on the falling edge; bit 0 is held to the end.
                        if (bit_q != 3'd0) begin
                            shreg_d = {shreg_q[6:0], 1'b0};
                        end
                    end else if (bit_q == 3'd0) begin
                        state_d = StGap;
                    end else begin
                        high_d = 1'b1;
                        bit_d  = bit_q - 3'd1;
                    end
                end
            end

            StGap: begin
                div_d = div_q + 8'd1;
                if (div_done) begin
                    div_d   = 8'd0;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StGap) && div_done;
    assign bus.cs_n = (state_q == StIdle) || (state_q == StGap);
    assign bus.sclk = (state_q == StShift) && high_q;
    assign bus.mosi = ((state_q == StSetup) || (state_q == StShift)) && shreg_q[7];

endmodule

// File: doc/spi_segment_master.md
# spi_segment_master

SPI initiator that serialises an 8-bit segment pattern to the SPI segment controller (the display-side responder). One `start` pulse sends one 8-bit frame in SPI mode 0, MSB first, framed by an active-low chip select. An optional auto-refresh timer resends the last pattern periodically so the display recovers after a glitch. The block sits in the host-side tile, driving the three-wire link (`sclk`, `mosi`, `cs_n`) that the segment controller receives.

## Interface
- `CLK_DIV`, 8'd4: `clk` cycles per SCLK half-period. Legal range 1..255; 0 is illegal.
- `REFRESH_COUNT`, 24'd10_000_000: idle `clk` cycles before the last frame is resent automatically. 0 disables auto-refresh.

- `clk`  input  1  system clock; all logic updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request to send one frame. Sampled only when `busy`=0.
- `data`  input  8  segment pattern. Captured in the cycle `start` is accepted.
- `busy`  output  1  high from the cycle after acceptance to the end of the frame.
- `done`  output  1  one-cycle pulse in the last busy cycle of each frame.
- `sclk`  output  1  SPI clock. Idles low (CPOL=0).
- `mosi`  output  1  serial data, MSB first.
- `cs_n`  output  1  chip select, active low.

## Operation
- **Reset values:** `busy`=0, `done`=0, `sclk`=0, `mosi`=0, `cs_n`=1. The shift register, divider counter, bit counter and refresh counter are all cleared, and the "frame sent" flag is cleared.
- **Reset mid-frame:** all outputs return to their reset values immediately (asynchronously). The partial frame is abandoned and is not resumed.
- **States:**
  - IDLE: `cs_n`=1, `sclk`=0, `mosi`=0.
  - SETUP: `cs_n`=0, `sclk`=0, `mosi`=`data[7]`. Lasts CLK_DIV cycles.
  - SHIFT: 8 bits. Each bit is a high half of CLK_DIV cycles followed by a low half of CLK_DIV cycles.
  - GAP: `cs_n`=1, `sclk`=0, `mosi`=0. Lasts CLK_DIV cycles.
- **Transitions:**
  - IDLE→SETUP on an accepted `start` or a refresh trigger.
  - SETUP→SHIFT when the divider expires.
  - SHIFT→GAP after the low half of bit 0.
  - GAP→IDLE when the divider expires.
- **Shifting:** `mosi` changes only while `sclk` is low, i.e. at falling-edge boundaries. The responder samples on the rising `sclk` edge. Bit 7 is presented in SETUP; bits 6..0 are presented at successive falling edges.
- **Start handshake:**
  - `start` while `busy`=1 is ignored; there is no queue.
  - `start` in the same cycle that `busy` falls is also ignored.
  - `start` held high continuously produces back-to-back frames separated by one IDLE cycle.
- **Auto-refresh:**
  - The 24-bit counter increments each IDLE cycle and clears on any frame start.
  - When it reaches REFRESH_COUNT, the "frame sent" flag is set and REFRESH_COUNT≠0, the block resends the held pattern. This behaves exactly like a user start.
  - An explicit `start` in the same cycle as a refresh trigger wins: new `data` is captured.
  - The refresh counter saturates if the "frame sent" flag is clear.
- **Data hold:** the held pattern is updated only on an accepted `start`. `data` changes during a frame have no effect.

## Timing
- `start` is sampled at clock edge 0. In cycle 1, `busy`=1, `cs_n`=0, `sclk`=0 and `mosi`=`data[7]`.
- The first rising `sclk` occurs at cycle CLK_DIV+1. Rising edge k (k=1..8) occurs at cycle 1+CLK_DIV·(2k−1).
- `cs_n` rises at cycle 1+17·CLK_DIV, which begins GAP.
- `done`=1 in cycle 18·CLK_DIV, the last busy cycle. `busy`=0 from cycle 18·CLK_DIV+1.
- `busy` lasts exactly 18·CLK_DIV cycles per frame.
- The earliest next start is sampled at edge 18·CLK_DIV+1.
- A refresh frame starts on the cycle after the counter reaches REFRESH_COUNT and follows the same timing.

## Test plan
- **Reset:** with CLK_DIV=2, assert `rst` mid-SHIFT → in the same cycle `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0; no `done` pulse follows.
- **Basic frame:** with CLK_DIV=2, `data`=8'hA5 and a 1-cycle `start` → `mosi` sampled at the 8 rising edges reads 1,0,1,0,0,1,0,1. There are exactly 8 `sclk` rising edges, `busy` is high for 36 cycles, and `done` pulses once in cycle 36.
- **Start while busy:** with CLK_DIV=1, `data`=8'h3C, then `start` with `data`=8'hFF at cycle 5 → one frame carrying 0x3C only, and `busy` high for 18 cycles.
- **Held start:** with CLK_DIV=1, `start` held high and `data`=8'h81 → consecutive frames each 18 busy cycles long, separated by exactly one IDLE cycle with `cs_n`=1.
- **Auto-refresh:** with REFRESH_COUNT=20, CLK_DIV=1, send 8'h6D, then leave `start` low → an identical 0x6D frame starts 21 cycles after `busy` falls. No refresh occurs after reset before the first frame.
- **Refresh/start collision:** with REFRESH_COUNT=20, assert `start` with `data`=8'h07 in the refresh trigger cycle → a single frame carrying 0x07, and the refresh counter restarts from 0.
